// File: rtl/bls_serial_sub_ctrl.sv
// bls_serial_sub_ctrl: wide subtractor D = A - B - bin computed one nibble per
// clock by reusing a single 4-bit borrow-lookahead slice, LSB nibble first.
// Optional feature macro: BLS_SIGNED_OVF_EN adds a signed-overflow output ovf.

// 4-bit borrow-lookahead subtractor slice: D = A - B - bin mod 16.
module bls4_slice (
  input  logic [3:0] A,
  input  logic [3:0] B,
  input  logic       bin,
  output logic [3:0] D,
  output logic       bout
);
  logic [3:0] w_g;   // nibble bit generates a borrow (a=0, b=1)
  logic [3:0] w_p;   // nibble bit passes an incoming borrow (a==b)
  logic [3:0] w_c;   // borrow into each bit

  assign w_g = ~A & B;
  assign w_p = ~(A ^ B);

  assign w_c[0] = bin;
  assign w_c[1] = w_g[0] | (w_p[0] & bin);
  assign w_c[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & bin);
  assign w_c[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
                | (w_p[2] & w_p[1] & w_p[0] & bin);
  assign bout   = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
                | (w_p[3] & w_p[2] & w_p[1] & w_g[0])
                | (w_p[3] & w_p[2] & w_p[1] & w_p[0] & bin);

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_diff
      assign D[gi] = A[gi] ^ B[gi] ^ w_c[gi];
    end
  endgenerate
endmodule

module bls_serial_sub_ctrl #(
  parameter int NIBBLES = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [4*NIBBLES-1:0] A,
  input  logic [4*NIBBLES-1:0] B,
  input  logic                 bin,
  output logic                 busy,
  output logic                 done,
  output logic [4*NIBBLES-1:0] D,
`ifdef BLS_SIGNED_OVF_EN
  output logic                 ovf,
`endif
  output logic                 bout
);
  localparam int W  = 4 * NIBBLES;
  localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t          r_state;
  state_t          w_state_next;
  logic [W-1:0]    r_opa;
  logic [W-1:0]    r_opb;
  logic [W-1:0]    r_acc;
  logic [W-1:0]    r_d;
  logic            r_borrow;
  logic            r_bout;
  logic [IW-1:0]   r_idx;
  logic [3:0]      w_slice_d;
  logic            w_slice_bout;
  logic [W-1:0]    w_acc_shift;
  logic [W-1:0]    w_opa_shift;
  logic [W-1:0]    w_opb_shift;
  logic            w_last;

  bls4_slice u_slice (
    .A    (r_opa[3:0]),
    .B    (r_opb[3:0]),
    .bin  (r_borrow),
    .D    (w_slice_d),
    .bout (w_slice_bout)
  );

  // A single-nibble build has nothing above the slice to shift down.
  generate
    if (NIBBLES == 1) begin : g_one
      assign w_acc_shift = w_slice_d;
      assign w_opa_shift = '0;
      assign w_opb_shift = '0;
    end else begin : g_many
      assign w_acc_shift = {w_slice_d, r_acc[W-1:4]};
      assign w_opa_shift = {4'b0000, r_opa[W-1:4]};
      assign w_opb_shift = {4'b0000, r_opb[W-1:4]};
    end
  endgenerate

  assign w_last = (r_state == S_RUN) && (r_idx == IW'(NIBBLES - 1));

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_next;
  end

  // Next-state logic: start is only looked at in IDLE.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_state_next = S_RUN;
      S_RUN:   if (w_last) w_state_next = S_DONE;
      S_DONE:  w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // Handshake outputs decoded from state.
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (r_state)
      S_RUN:   busy = 1'b1;
      S_DONE:  done = 1'b1;
      default: ;
    endcase
  end

`ifdef BLS_SIGNED_OVF_EN
  logic r_a_msb;   // operand sign bits kept because opA/opB shift away
  logic r_b_msb;
  logic r_ovf;

  // Signed overflow evaluated on the completing edge from captured signs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_a_msb <= 1'b0;
      r_b_msb <= 1'b0;
      r_ovf   <= 1'b0;
    end else if (r_state == S_IDLE && start) begin
      r_a_msb <= A[W-1];
      r_b_msb <= B[W-1];
    end else if (w_last) begin
      r_ovf <= (r_a_msb != r_b_msb) && (w_slice_d[3] != r_a_msb);
    end
  end

  assign ovf = r_ovf;
`endif

  // Operand capture, per-nibble stepping and result commit on the last nibble.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_opa    <= '0;
      r_opb    <= '0;
      r_acc    <= '0;
      r_d      <= '0;
      r_borrow <= 1'b0;
      r_bout   <= 1'b0;
      r_idx    <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_opa    <= A;
            r_opb    <= B;
            r_borrow <= bin;
            r_idx    <= '0;
          end
        end
        S_RUN: begin
          r_acc    <= w_acc_shift;
          r_opa    <= w_opa_shift;
          r_opb    <= w_opb_shift;
          r_borrow <= w_slice_bout;
          r_idx    <= r_idx + IW'(1);
          if (w_last) begin
            r_d    <= w_acc_shift;
            r_bout <= w_slice_bout;
          end
        end
        default: ;
      endcase
    end
  end

  assign D    = r_d;
  assign bout = r_bout;
endmodule

// File: tb/tb_bls_serial_sub_ctrl.sv
// Scoreboard bench for bls_serial_sub_ctrl (NIBBLES=4). Expected results are
// hand-computed and queued when a start is issued; a monitor pops on done.
module tb_bls_serial_sub_ctrl;
  localparam int N = 4;
  localparam int W = 4 * N;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] A = '0;
  logic [W-1:0] B = '0;
  logic         bin = 1'b0;
  logic         busy;
  logic         done;
  logic [W-1:0] D;
  logic         bout;
`ifdef BLS_SIGNED_OVF_EN
  logic         ovf;
`endif

  typedef struct {
    logic [W-1:0] d;
    logic         b;
    logic         o;
  } exp_t;

  exp_t         q[$];
  int           n_tests = 0;
  int           n_fail = 0;
  int           busy_cnt = 0;
  logic [W-1:0] last_d = '0;
  logic         last_b = 1'b0;

  bls_serial_sub_ctrl #(.NIBBLES(N)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .A     (A),
    .B     (B),
    .bin   (bin),
    .busy  (busy),
    .done  (done),
    .D     (D),
`ifdef BLS_SIGNED_OVF_EN
    .ovf   (ovf),
`endif
    .bout  (bout)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: pops one expectation per done pulse and checks hold behaviour.
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        busy_cnt = 0;
        last_d   = '0;
        last_b   = 1'b0;
      end else begin
        if (busy) begin
          busy_cnt++;
          check("hold_d_busy", {16'h0, D}, {16'h0, last_d});
          check("hold_bout_busy", {31'h0, bout}, {31'h0, last_b});
        end
        if (done) begin
          check("busy_len", busy_cnt, N);
          check("done_not_busy", {31'h0, busy}, 32'h0);
          busy_cnt = 0;
          if (q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_done: got done=1 expected no done");
          end else begin
            exp_t e;
            e = q.pop_front();
            check("result_d", {16'h0, D}, {16'h0, e.d});
            check("result_bout", {31'h0, bout}, {31'h0, e.b});
`ifdef BLS_SIGNED_OVF_EN
            check("result_ovf", {31'h0, ovf}, {31'h0, e.o});
`endif
            $display("[TB] done: D=%h bout=%b (exp D=%h bout=%b)", D, bout, e.d, e.b);
            last_d = e.d;
            last_b = e.b;
          end
        end
      end
    end
  end

  task automatic launch(input logic [W-1:0] a, input logic [W-1:0] b, input logic bi,
                        input logic [W-1:0] ed, input logic eb, input logic eo,
                        input bit push);
    exp_t e;
    @(negedge clk);
    A = a; B = b; bin = bi; start = 1'b1;
    if (push) begin
      e.d = ed; e.b = eb; e.o = eo;
      q.push_back(e);
    end
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    while ((q.size() != 0 || busy || done) && k < 100) begin
      @(negedge clk);
      k++;
    end
    if (k >= 100) begin
      n_tests++;
      n_fail++;
      $display("FAIL timeout: got queue=%0d expected 0 within 100 cycles", q.size());
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("rst_busy", {31'h0, busy}, 32'h0);
    check("rst_done", {31'h0, done}, 32'h0);
    check("rst_d", {16'h0, D}, 32'h0);
    check("rst_bout", {31'h0, bout}, 32'h0);
    rst = 1'b0;

    launch(16'h1234, 16'h0234, 1'b0, 16'h1000, 1'b0, 1'b0, 1); wait_idle();
    launch(16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, 1'b0, 1); wait_idle();
    launch(16'h1000, 16'h0001, 1'b0, 16'h0FFF, 1'b0, 1'b0, 1); wait_idle();
    launch(16'h0005, 16'h0005, 1'b1, 16'hFFFF, 1'b1, 1'b0, 1); wait_idle();
    launch(16'hFFFF, 16'h0000, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1); wait_idle();
    launch(16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b1, 1); wait_idle();
    launch(16'h7FFF, 16'hFFFF, 1'b0, 16'h8000, 1'b1, 1'b1, 1); wait_idle();
    launch(16'h0003, 16'h0001, 1'b0, 16'h0002, 1'b0, 1'b0, 1); wait_idle();

    // Second start during RUN must be ignored; operand changes must not leak in.
    launch(16'h00FF, 16'h000F, 1'b0, 16'h00F0, 1'b0, 1'b0, 1);
    @(negedge clk);
    A = 16'h0000; B = 16'h0001; start = 1'b1;
    @(negedge clk);
    start = 1'b0; A = 16'h5555; B = 16'h3333; bin = 1'b1;
    wait_idle();
    repeat (10) @(negedge clk);

    // Reset sampled two edges after the accepted start aborts the operation.
    launch(16'hABCD, 16'h1234, 1'b0, 16'h0, 1'b0, 1'b0, 0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("abort_busy", {31'h0, busy}, 32'h0);
    check("abort_done", {31'h0, done}, 32'h0);
    check("abort_d", {16'h0, D}, 32'h0);
    check("abort_bout", {31'h0, bout}, 32'h0);
    rst = 1'b0;
    repeat (10) @(negedge clk);

    launch(16'hABCD, 16'h1234, 1'b0, 16'h9999, 1'b0, 1'b0, 1); wait_idle();
    repeat (4) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/bls_serial_sub_ctrl.md
Name: bls_serial_sub_ctrl

Overview:
Sequencer that reuses a single 4-bit borrow-lookahead subtractor slice to compute a wide subtraction D = A - B - bin, one nibble per clock, least-significant nibble first. It captures the operands, steps the nibble index and feeds the ripple borrow from one nibble into the next. It presents a start/busy/done handshake to the surrounding lab datapath. The slice is the team's existing gate-level 4-bit BLS: ports A, B, bin, D, bout, with D = A - B - bin mod 16 and bout = borrow out. It is instantiated once inside this block.

Parameters:
NIBBLES, 4, number of 4-bit nibbles; operand width W = 4*NIBBLES; legal range 1..16.

Ports:
clk  input  1  single system clock; all state changes on the rising edge.
rst  input  1  synchronous reset, active-high.
start  input  1  request; sampled only in IDLE.
A  input  W  minuend; captured on the accepted start.
B  input  W  subtrahend; captured on the accepted start.
bin  input  1  borrow-in to nibble 0; captured on the accepted start.
busy  output  1  high while in RUN.
done  output  1  one-cycle pulse when the result is valid.
D  output  W  difference register; holds the last result.
bout  output  1  borrow out of the top nibble; holds the last result.

Behaviour:
- Reset: state=IDLE; busy=0; done=0; D=0; bout=0; nibble index=0; internal borrow=0; operand and accumulator registers=0.
- FSM states: IDLE, RUN, DONE.
  - IDLE -> RUN when start=1. On that edge: latch A, B and bin into shift registers opA, opB and the borrow flop; clear the index.
  - RUN, each edge:
    - Slice inputs are opA[3:0], opB[3:0] and the borrow flop.
    - Slice D shifts into the top nibble of the accumulator (the accumulator shifts right 4).
    - Slice bout loads the borrow flop.
    - opA and opB shift right 4; index increments.
  - RUN -> DONE on the edge where index == NIBBLES-1 is processed. On that same edge, D <= final accumulator value and bout <= final slice bout.
  - DONE -> IDLE unconditionally after one cycle.
- Timing: start sampled at edge t0; busy=1 from t0 through t0+NIBBLES; done=1 and busy=0 for exactly the cycle following edge t0+NIBBLES. Latency is NIBBLES cycles.
- D and bout change only at completion. They are stable during RUN and DONE and until the next completion.
- start in RUN or DONE is ignored; there is no queuing. start held high in IDLE re-launches each time IDLE is re-entered.
- Changes on A, B or bin after capture have no effect on the result in progress.
- Arithmetic: result = (A - B - bin) mod 2^W; bout=1 iff A < B + bin (unsigned).
- NIBBLES=1 runs for one cycle, RUN -> DONE directly.
- Reset in any state, including mid-RUN, aborts immediately to reset values. No done is issued for the aborted operation.

Optional Feature:
BLS_SIGNED_OVF_EN
- Defined: adds output port ovf (1 bit, reset 0). It is updated with D at completion: ovf = (A[W-1] != B[W-1]) && (D[W-1] != A[W-1]), using the captured operands. The bin contribution is included in D.
- Undefined: no ovf port and no related logic. All other behaviour is identical.

Test Plan:
- NIBBLES=4, A=16'h1234, B=16'h0234, bin=0, start at t0 -> done pulse at t0+4, D=16'h1000, bout=0; busy=1 for 4 cycles.
- A=16'h0000, B=16'h0001, bin=0 -> D=16'hFFFF, bout=1 (borrow ripples through all 4 nibbles).
- A=16'h1000, B=16'h0001, bin=0 -> D=16'h0FFF, bout=0. Second case A=16'h0005, B=16'h0005, bin=1 -> D=16'hFFFF, bout=1.
- Launch A=16'h00FF, B=16'h000F. Pulse start again with A=0, B=1 two cycles later; also change A/B mid-RUN -> second start ignored; D=16'h00F0, bout=0; exactly one done.
- Launch, then assert rst at t0+2 -> next cycle busy=0, done=0, D=0, bout=0; no done follows. A fresh start afterwards completes normally.
- BLS_SIGNED_OVF_EN defined: A=16'h8000, B=16'h0001 -> D=16'h7FFF, ovf=1, bout=0. A=16'h7FFF, B=16'hFFFF -> D=16'h8000, ovf=1, bout=1. A=16'h0003, B=16'h0001 -> ovf=0.
